// File: rtl/mul_exec_unit.sv
// Three-stage pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
// Produces the one-cycle execution-finish broadcast for the multiply pipe.
module mul_exec_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_issue_vld,
    input  logic [1:0]        i_issue_op,
    input  logic [DATA_W-1:0] i_issue_src1,
    input  logic [DATA_W-1:0] i_issue_src2,
    input  logic [TAG_W-1:0]  i_issue_rrftag,
    input  logic              i_kill,
    output logic              o_exfin_mul,
    output logic [TAG_W-1:0]  o_ex_mul_rrftag,
    output logic [DATA_W-1:0] o_exfin_mul_res,
    output logic [1:0]        o_inflight_cnt
);

    localparam int OPW = DATA_W + 1;
    localparam int PW  = 2 * DATA_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    function automatic logic [DATA_W-1:0] select_res(input logic [1:0] op,
                                                     input logic signed [PW-1:0] prod);
        if (op == OP_MUL) begin
            return prod[DATA_W-1:0];
        end
        return prod[PW-1:DATA_W];
    endfunction

    logic                     vld_p1_d, vld_p1_q;
    logic [1:0]               op_p1_d, op_p1_q;
    logic [TAG_W-1:0]         tag_p1_d, tag_p1_q;
    logic signed [OPW-1:0]    a_p1_d, a_p1_q;
    logic signed [OPW-1:0]    b_p1_d, b_p1_q;

    logic                     vld_p2_d, vld_p2_q;
    logic [1:0]               op_p2_d, op_p2_q;
    logic [TAG_W-1:0]         tag_p2_d, tag_p2_q;
    logic signed [PW-1:0]     prod_p2_d, prod_p2_q;

    logic                     vld_p3_d, vld_p3_q;
    logic [TAG_W-1:0]         tag_p3_d, tag_p3_q;
    logic [DATA_W-1:0]        res_p3_d, res_p3_q;
    logic [1:0]               cnt_d, cnt_q;

    always_comb begin
        // S1: sign/zero-extend operands to 33 bits
        vld_p1_d = i_issue_vld & ~i_kill;
        op_p1_d  = i_issue_op;
        tag_p1_d = i_issue_rrftag;
        a_p1_d   = {((i_issue_op == OP_MULH) || (i_issue_op == OP_MULHSU)) & i_issue_src1[DATA_W-1],
                    i_issue_src1};
        b_p1_d   = {(i_issue_op == OP_MULH) & i_issue_src2[DATA_W-1], i_issue_src2};

        // S2: product; bits above 2*DATA_W are never selected, so they are not kept
        vld_p2_d  = vld_p1_q & ~i_kill;
        op_p2_d   = op_p1_q;
        tag_p2_d  = tag_p1_q;
        prod_p2_d = {{(DATA_W-1){a_p1_q[OPW-1]}}, a_p1_q} * {{(DATA_W-1){b_p1_q[OPW-1]}}, b_p1_q};

        // S3: output register, data held unless a valid op enters
        vld_p3_d = vld_p2_q & ~i_kill;
        tag_p3_d = tag_p3_q;
        res_p3_d = res_p3_q;
        if (vld_p3_d) begin
            tag_p3_d = tag_p2_q;
            res_p3_d = select_res(op_p2_q, prod_p2_q);
        end

        cnt_d = {1'b0, vld_p1_d} + {1'b0, vld_p2_d} + {1'b0, vld_p3_d};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            tag_p3_q <= '0;
            res_p3_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            tag_p3_q <= tag_p3_d;
            res_p3_q <= res_p3_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        op_p1_q   <= op_p1_d;
        tag_p1_q  <= tag_p1_d;
        a_p1_q    <= a_p1_d;
        b_p1_q    <= b_p1_d;
        op_p2_q   <= op_p2_d;
        tag_p2_q  <= tag_p2_d;
        prod_p2_q <= prod_p2_d;
    end

    assign o_exfin_mul     = vld_p3_q;
    assign o_ex_mul_rrftag = tag_p3_q;
    assign o_exfin_mul_res = res_p3_q;
    assign o_inflight_cnt  = cnt_q;

endmodule
